// File: rtl/decode_instr_queue_pkg.sv
// Shared decode-side definitions: word width, bubble encoding and
// the dispatch_take encoding used by fetch, decode and dispatch.
package decode_instr_queue_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_WORD = '0;

    typedef logic [1:0] take_t;

    localparam take_t TAKE_NONE = 2'd0;
    localparam take_t TAKE_ONE  = 2'd1;
    localparam take_t TAKE_TWO  = 2'd2;

endpackage

// File: rtl/decode_instr_queue_insn_ring_ram.sv
// Instruction ring storage: two write ports for the tail pair and two
// asynchronous read ports for the head pair. Contents are not reset.
module insn_ring_ram
    import decode_instr_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we0_i,
    input  logic [AW-1:0]   waddr0_i,
    input  logic [XLEN-1:0] wdata0_i,
    input  logic            we1_i,
    input  logic [AW-1:0]   waddr1_i,
    input  logic [XLEN-1:0] wdata1_i,
    input  logic [AW-1:0]   raddr0_i,
    output logic [XLEN-1:0] rdata0_o,
    input  logic [AW-1:0]   raddr1_i,
    output logic [XLEN-1:0] rdata1_o
);

    logic [XLEN-1:0] mem_q [DEPTH];

    // Write the accepted words; the two addresses never collide.
    always_ff @(posedge clk) begin
        if (we0_i) mem_q[waddr0_i] <= wdata0_i;
        if (we1_i) mem_q[waddr1_i] <= wdata1_i;
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/decode_instr_queue.sv
// Decode instruction queue: filters fetch bubbles, buffers the pair
// stream in order, and offers the two oldest entries to dispatch.
module decode_instr_queue
    import decode_instr_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] in_instr1,
    input  logic [XLEN-1:0] in_instr2,
    output logic            fetch_stall,
    input  logic            flush,
    output logic            out_valid1,
    output logic [XLEN-1:0] out_instr1,
    output logic            out_valid2,
    output logic [XLEN-1:0] out_instr2,
    input  take_t           dispatch_take,
    output logic [CW-1:0]   count
);

    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [1:0]      vcnt;
    logic [1:0]      take_eff;
    logic [1:0]      enq_n;
    logic            acc, w1, w2;
    logic            we0, we1;
    logic [XLEN-1:0] wdata0;
    logic [XLEN-1:0] rdata0, rdata1;

    // Room for a full pair is needed before fetch may advance.
    assign fetch_stall = count_q > CW'(DEPTH - 2);

    assign vcnt     = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
    assign take_eff = (dispatch_take > vcnt) ? vcnt : dispatch_take;

    assign acc   = !flush && !fetch_stall;
    assign w1    = in_instr1 != NOP_WORD;
    assign w2    = in_instr2 != NOP_WORD;
    assign enq_n = acc ? ({1'b0, w1} + {1'b0, w2}) : 2'd0;

    // A lone surviving word always lands at the tail slot.
    assign we0    = acc && (w1 || w2);
    assign we1    = acc && w1 && w2;
    assign wdata0 = w1 ? in_instr1 : in_instr2;

    // Next pointer/count state; a flush empties the queue outright.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + AW'(take_eff);
            tail_d  = tail_q + AW'(enq_n);
            count_d = count_q - CW'(take_eff) + CW'(enq_n);
        end
    end

    // Pointer and occupancy registers; reset beats everything else.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Dispatch must never take more than is currently offered.
    always_ff @(posedge clk) begin
        if (reset_n && !flush) begin
            assert (dispatch_take <= vcnt);
        end
    end

    insn_ring_ram #(.DEPTH(DEPTH)) u_ram (
        .clk      (clk),
        .we0_i    (we0),
        .waddr0_i (tail_q),
        .wdata0_i (wdata0),
        .we1_i    (we1),
        .waddr1_i (tail_q + AW'(1)),
        .wdata1_i (in_instr2),
        .raddr0_i (head_q),
        .rdata0_o (rdata0),
        .raddr1_i (head_q + AW'(1)),
        .rdata1_o (rdata1)
    );

    assign out_valid1 = count_q != '0;
    assign out_valid2 = count_q >= CW'(2);
    assign out_instr1 = out_valid1 ? rdata0 : NOP_WORD;
    assign out_instr2 = out_valid2 ? rdata1 : NOP_WORD;
    assign count      = count_q;

endmodule

// File: tb/tb_decode_instr_queue.sv
// Bench for decode_instr_queue: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.
module tb_decode_instr_queue;
    import decode_instr_queue_pkg::*;

    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [XLEN-1:0] in_instr1, in_instr2;
    logic            fetch_stall;
    logic            flush;
    logic            out_valid1, out_valid2;
    logic [XLEN-1:0] out_instr1, out_instr2;
    take_t           dispatch_take;
    logic [3:0]      count;

    int n_tot  = 0;
    int n_pass = 0;
    logic [XLEN-1:0] mq[$];

    decode_instr_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_instr1     (in_instr1),
        .in_instr2     (in_instr2),
        .fetch_stall   (fetch_stall),
        .flush         (flush),
        .out_valid1    (out_valid1),
        .out_instr1    (out_instr1),
        .out_valid2    (out_valid2),
        .out_instr2    (out_instr2),
        .dispatch_take (dispatch_take),
        .count         (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tot++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic chk_model();
        int sz;
        sz = mq.size();
        chk("count", 64'(count), 64'(sz));
        chk("valid1", 64'(out_valid1), 64'(sz >= 1));
        chk("valid2", 64'(out_valid2), 64'(sz >= 2));
        chk("instr1", 64'(out_instr1), (sz >= 1) ? 64'(mq[0]) : 64'h0);
        chk("instr2", 64'(out_instr2), (sz >= 2) ? 64'(mq[1]) : 64'h0);
        chk("stall", 64'(fetch_stall), 64'((DEPTH - sz) < 2));
    endtask

    // Called at a negedge: drive, check state, take the edge, update model.
    task automatic step(input logic r, input logic f,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [1:0] t);
        logic stl;
        int   n;
        reset_n       = r;
        flush         = f;
        in_instr1     = a;
        in_instr2     = b;
        dispatch_take = t;
        chk_model();
        stl = (DEPTH - mq.size()) < 2;
        @(posedge clk);
        if (!r || f) begin
            mq.delete();
        end else begin
            n = (int'(t) > mq.size()) ? mq.size() : int'(t);
            repeat (n) void'(mq.pop_front());
            if (!stl) begin
                if (a != NOP_WORD) mq.push_back(a);
                if (b != NOP_WORD) mq.push_back(b);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [XLEN-1:0] a, b;
        logic [1:0]      t;
        int              mx;

        reset_n = 1'b0; flush = 1'b0;
        in_instr1 = '0; in_instr2 = '0; dispatch_take = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mq.delete();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_v1", 64'(out_valid1), 64'd0);
        chk("rst_v2", 64'(out_valid2), 64'd0);
        chk("rst_i1", 64'(out_instr1), 64'h0);
        chk("rst_i2", 64'(out_instr2), 64'h0);
        chk("rst_stall", 64'(fetch_stall), 64'd0);

        step(1, 0, 32'h00500093, 32'h00A00113, 0);
        chk("pair_cnt", 64'(count), 64'd2);
        chk("pair_i1", 64'(out_instr1), 64'h00500093);
        chk("pair_i2", 64'(out_instr2), 64'h00A00113);
        step(1, 0, 32'h0, 32'h00100193, 0);
        chk("bub_cnt", 64'(count), 64'd3);
        step(1, 0, 32'h0, 32'h0, 0);
        chk("bub0_cnt", 64'(count), 64'd3);

        step(0, 0, 32'h0, 32'h0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 32'h100 + 32'(2*i), 32'h101 + 32'(2*i), 0);
            chk("bp_cnt", 64'(count), 64'(2*i + 2));
        end
        chk("bp_stall8", 64'(fetch_stall), 64'd1);
        step(1, 0, 32'hAAA1, 32'hAAA2, 0);
        chk("bp_hold8", 64'(count), 64'd8);
        step(1, 0, 32'hAAA1, 32'hAAA2, 1);
        chk("bp_cnt7", 64'(count), 64'd7);
        chk("bp_stall7", 64'(fetch_stall), 64'd1);
        step(1, 0, 32'hAAA1, 32'hAAA2, 1);
        chk("bp_cnt6", 64'(count), 64'd6);
        chk("bp_stall6", 64'(fetch_stall), 64'd0);
        step(1, 0, 32'hAAA1, 32'hAAA2, 0);
        chk("bp_refill", 64'(count), 64'd8);
        repeat (4) step(1, 0, 32'h0, 32'h0, 2);
        chk("bp_drain", 64'(count), 64'd0);

        step(0, 0, 32'h0, 32'h0, 0);
        step(1, 0, 32'h201, 32'h202, 0);
        step(1, 0, 32'h203, 32'h204, 0);
        step(1, 0, 32'h205, 32'h206, 0);
        repeat (3) step(1, 0, 32'h0, 32'h0, 2);
        step(1, 0, 32'h207, 32'h208, 0);
        step(1, 0, 32'h0, 32'h209, 0);
        chk("wr_cnt3", 64'(count), 64'd3);
        step(1, 0, 32'h20A, 32'h20B, 2);
        chk("wr_cnt", 64'(count), 64'd3);
        chk("wr_i1", 64'(out_instr1), 64'h209);
        chk("wr_i2", 64'(out_instr2), 64'h20A);

        step(0, 0, 32'h0, 32'h0, 0);
        step(1, 0, 32'h301, 32'h302, 0);
        step(1, 0, 32'h303, 32'h304, 0);
        step(1, 0, 32'h305, 32'h0, 0);
        chk("fl_cnt5", 64'(count), 64'd5);
        step(1, 1, 32'h306, 32'h307, 2);
        chk("fl_cnt", 64'(count), 64'd0);
        chk("fl_v1", 64'(out_valid1), 64'd0);
        step(1, 0, 32'h311, 32'h312, 0);
        step(1, 0, 32'h313, 32'h314, 0);
        step(1, 0, 32'h0, 32'h315, 0);
        step(0, 1, 32'h316, 32'h317, 2);
        chk("rf_cnt", 64'(count), 64'd0);
        chk("rf_v1", 64'(out_valid1), 64'd0);
        chk("rf_stall", 64'(fetch_stall), 64'd0);

        for (int i = 0; i < 400; i++) begin
            a  = ($urandom % 4 == 0) ? 32'h0 : $urandom;
            b  = ($urandom % 4 == 0) ? 32'h0 : $urandom;
            mx = (mq.size() >= 2) ? 2 : mq.size();
            t  = 2'($urandom_range(mx, 0));
            step(($urandom % 50) != 0, ($urandom % 20) == 0, a, b, t);
        end
        chk_model();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
